if_id_decode: RTL

IF_ID_DECODE -- requirements
Module: if_id_decode

---
 rtl/if_id_decode.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with RV32I immediate field extraction and extension-select decode.
// Holds on stall, bubbles on flush, and counts stalled valid cycles with saturation.
module if_id_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [5:0]  EXTOp,
  output logic        id_illegal,
  output logic [15:0] stall_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  ext_dec;
  logic        illegal_dec;

  logic        load_valid;
  logic        hold;
  logic        cnt_inc;

  logic        id_valid_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_instr_next;
  logic [4:0]  iimm_shamt_next;
  logic [11:0] iimm_next;
  logic [11:0] simm_next;
  logic [11:0] bimm_next;
  logic [19:0] uimm_next;
  logic [19:0] jimm_next;
  logic [5:0]  ext_next;
  logic        illegal_next;
  logic [15:0] stall_cnt_next;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];

  // Extension select from the incoming word, so it lands in the same edge as id_instr.
  always_comb begin
    ext_dec     = 6'b000000;
    illegal_dec = 1'b0;
    case (opcode)
      7'b0010011: ext_dec = (funct3 == 3'b001 || funct3 == 3'b101) ? 6'b100000 : 6'b010000;
      7'b0000011,
      7'b1100111: ext_dec = 6'b010000;
      7'b0100011: ext_dec = 6'b001000;
      7'b1100011: ext_dec = 6'b000100;
      7'b0110111,
      7'b0010111: ext_dec = 6'b000010;
      7'b1101111: ext_dec = 6'b000001;
      7'b0110011,
      7'b1110011,
      7'b0001111: ext_dec = 6'b000000;
      default:    illegal_dec = 1'b1;
    endcase
  end

  // Priority: rst > flush > stall > load; anything not held or loaded becomes a bubble.
  assign hold       = !rst && !flush && stall;
  assign load_valid = !rst && !flush && !stall && if_valid;
  assign cnt_inc    = hold && id_valid && (stall_cnt != 16'hFFFF);

  always_comb begin
    id_valid_next   = 1'b0;
    id_pc_next      = 32'h0;
    id_instr_next   = NOP_INSTR;
    iimm_shamt_next = 5'd0;
    iimm_next       = 12'h0;
    simm_next       = 12'h0;
    bimm_next       = 12'h0;
    uimm_next       = 20'h0;
    jimm_next       = 20'h0;
    ext_next        = 6'b000000;
    illegal_next    = 1'b0;
    if (hold) begin
      id_valid_next   = id_valid;
      id_pc_next      = id_pc;
      id_instr_next   = id_instr;
      iimm_shamt_next = iimm_shamt;
      iimm_next       = iimm;
      simm_next       = simm;
      bimm_next       = bimm;
      uimm_next       = uimm;
      jimm_next       = jimm;
      ext_next        = EXTOp;
      illegal_next    = id_illegal;
    end else if (load_valid) begin
      id_valid_next   = 1'b1;
      id_pc_next      = if_pc;
      id_instr_next   = if_instr;
      iimm_shamt_next = if_instr[24:20];
      iimm_next       = if_instr[31:20];
      simm_next       = {if_instr[31:25], if_instr[11:7]};
      bimm_next       = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8]};
      uimm_next       = if_instr[31:12];
      jimm_next       = {if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21]};
      ext_next        = ext_dec;
      illegal_next    = illegal_dec;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt;
    if (rst)
      stall_cnt_next = 16'h0;
    else if (cnt_inc)
      stall_cnt_next = stall_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    id_valid   <= id_valid_next;
    id_pc      <= id_pc_next;
    id_instr   <= id_instr_next;
    iimm_shamt <= iimm_shamt_next;
    iimm       <= iimm_next;
    simm       <= simm_next;
    bimm       <= bimm_next;
    uimm       <= uimm_next;
    jimm       <= jimm_next;
    EXTOp      <= ext_next;
    id_illegal <= illegal_next;
    stall_cnt  <= stall_cnt_next;
  end

endmodule
